fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage for the 16-bit processor, driven by the 2-bit fetch/decode/execute state code from the FDE state machine.
- In FETCH it issues a read to instruction memory, waits for ready, latches the instruction word and increments the PC.
- In EXECUTE it applies a taken branch to the PC.
- Its stall output gates the state machine's enable, so FETCH persists until the instruction is captured.

Parameters:
ADDR_WIDTH, 16, width of PC and memory address (word-addressed)
DATA_WIDTH, 16, width of instruction word
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
en  input  1  global enable; when low all registers hold
state  input  2  FDE state code: 00 fetch, 01 decode, 10 execute, 11 memory (reserved)
mem_ready  input  1  memory read data valid this cycle
mem_rdata  input  DATA_WIDTH  instruction word from memory
branch_taken  input  1  execute-stage branch decision
branch_target  input  ADDR_WIDTH  branch destination address
mem_rd  output  1  registered read request
mem_addr  output  ADDR_WIDTH  registered read address
ir  output  DATA_WIDTH  instruction register
pc  output  ADDR_WIDTH  program counter (address of next fetch)
ir_valid  output  1  high once ir holds a fetched word; cleared by reset only
stall  output  1  combinational; top level drives FDE enable = en & ~stall

Behaviour:
- Reset (reset=1 at posedge, regardless of en):
  - pc=RESET_PC; ir=0; ir_valid=0; mem_rd=0; mem_addr=0; internal FSM=F_IDLE.
- en=0: every register holds, including mem_rd/mem_addr. stall is still computed from the held values.
- Internal FSM, updated only when en=1:
  - F_IDLE: if state==00, set mem_rd<=1, mem_addr<=pc, go to F_REQ. Otherwise stay.
  - F_REQ: mem_rd stays 1. If mem_ready=1: ir<=mem_rdata, ir_valid<=1, pc<=pc+1, mem_rd<=0, go to F_DONE. If mem_ready=0: stay (wait states unbounded).
  - F_DONE: go to F_IDLE unconditionally.
- stall = (state==00) && (FSM != F_DONE).
  - Zero-wait fetch holds FETCH for 3 cycles: IDLE, REQ, DONE. The FDE state advances to decode on the DONE cycle edge.
  - Each memory wait cycle adds one cycle.
- PC arithmetic: modulo 2^ADDR_WIDTH; pc=FFFF increments to 0000, no flag.
- Branch: at posedge with en=1, state==10 and branch_taken=1, pc<=branch_target. Otherwise pc changes only on fetch completion. The two never coincide because their state codes differ.
- state 01 and 11: no register activity apart from the F_DONE->F_IDLE transition.
- mem_ready outside F_REQ: ignored, ir unchanged.
- state leaves 00 while FSM is F_REQ (stall not honoured): abort. mem_rd<=0, FSM<=F_IDLE, pc/ir unchanged.
- Reset during F_REQ: request dropped on that edge; no ir update even if mem_ready=1 in the same cycle (reset has priority).
- mem_addr holds its last value after mem_rd drops.

Test Plan:
- Reset, then state=00 with mem_ready=1 on the REQ cycle and mem_rdata=16'hA5C3. Expect:
  - mem_rd=1 and mem_addr=0000 for one cycle;
  - ir=A5C3, ir_valid=1 and pc=0001 after the REQ edge;
  - stall high for 2 cycles, low on the 3rd.
- Same fetch with mem_ready delayed 4 cycles. Expect mem_rd and stall held high throughout; ir unchanged until ready; pc=0001 only after the ready edge.
- pc preloaded via branch_target=FFFF (state=10, branch_taken=1), then a fetch. Expect mem_addr=FFFF, and pc=0000 after the fetch.
- state=10, branch_taken=1, branch_target=1234. Expect pc=1234. Repeat with branch_taken=0: pc unchanged.
- en=0 for 3 cycles mid-F_REQ with mem_ready=1. Expect no ir/pc change and mem_rd held 1. Raise en: capture completes on the next edge.
- reset=1 in F_REQ with mem_ready=1, mem_rdata=BEEF. Expect ir=0, ir_valid=0, mem_rd=0 and pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory read bus between the fetch stage and the
//                instruction memory.
//                  mem_rd    - read request (driven by fetch stage)
//                  mem_addr  - word read address (driven by fetch stage)
//                  mem_ready - read data valid this cycle (driven by memory)
//                  mem_rdata - instruction word (driven by memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Fetch-stage side
    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    // Memory side
    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage of the 16-bit processor. While the
//                FDE state code is FETCH it issues one read to instruction
//                memory, waits (unbounded) for mem_ready, latches the word
//                into ir and increments pc. In EXECUTE a taken branch loads
//                pc from branch_target. stall holds the FDE machine in FETCH
//                until the instruction has been captured.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                en              - global enable, all registers hold when low
//                state[1:0]      - FDE state code (00 F, 01 D, 10 E, 11 M)
//                branch_taken    - execute-stage branch decision
//                branch_target   - branch destination address
//                mem             - instruction-memory bus (master side)
//                ir, ir_valid    - instruction register and its valid flag
//                pc              - address of next fetch
//                stall           - combinational; FDE enable = en & ~stall
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  en,
    input  wire logic [1:0]            state,
    input  wire logic                  branch_taken,
    input  wire logic [ADDR_WIDTH-1:0] branch_target,
    fetch_unit_if.master               mem,
    output logic [DATA_WIDTH-1:0]      ir,
    output logic [ADDR_WIDTH-1:0]      pc,
    output logic                       ir_valid,
    output logic                       stall
);

    localparam logic [1:0]            c_ST_FETCH = 2'b00;
    localparam logic [1:0]            c_ST_EXEC  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] c_PC_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_DONE = 2'd2
    } fstate_t;

    fstate_t               r_fsm;
    fstate_t               w_fsm_next;

    logic [ADDR_WIDTH-1:0] r_pc,       w_pc_next;
    logic [DATA_WIDTH-1:0] r_ir,       w_ir_next;
    logic                  r_ir_valid, w_ir_valid_next;
    logic                  r_mem_rd,   w_mem_rd_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm      <= F_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_valid <= w_ir_valid_next;
            r_mem_rd   <= w_mem_rd_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_next      = r_fsm;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_ir_valid_next = r_ir_valid;
        w_mem_rd_next   = r_mem_rd;
        w_mem_addr_next = r_mem_addr;

        if (en) begin
            unique case (r_fsm)
                F_IDLE: begin
                    if (state == c_ST_FETCH) begin
                        w_mem_rd_next   = 1'b1;
                        w_mem_addr_next = r_pc;
                        w_fsm_next      = F_REQ;
                    end
                end
                F_REQ: begin
                    if (state != c_ST_FETCH) begin
                        // FDE machine moved on without honouring stall:
                        // drop the outstanding request, keep pc/ir.
                        w_mem_rd_next = 1'b0;
                        w_fsm_next    = F_IDLE;
                    end else if (mem.mem_ready) begin
                        w_ir_next       = mem.mem_rdata;
                        w_ir_valid_next = 1'b1;
                        w_pc_next       = r_pc + c_PC_ONE;
                        w_mem_rd_next   = 1'b0;
                        w_fsm_next      = F_DONE;
                    end
                end
                F_DONE: begin
                    w_fsm_next = F_IDLE;
                end
                default: begin
                    w_fsm_next = F_IDLE;
                end
            endcase

            // Fetch completion only happens in FETCH, so it never collides
            // with a branch, which only happens in EXECUTE.
            if ((state == c_ST_EXEC) && branch_taken) begin
                w_pc_next = branch_target;
            end
        end
    end

    // F_DONE releases the stall so the FDE state advances on that edge.
    assign stall        = (state == c_ST_FETCH) && (r_fsm != F_DONE);

    assign pc           = r_pc;
    assign ir           = r_ir;
    assign ir_valid     = r_ir_valid;
    assign mem.mem_rd   = r_mem_rd;
    assign mem.mem_addr = r_mem_addr;

endmodule
`default_nettype wire
